// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: IF-stage FSM encoding and
// fetch-related constant words.
package mips_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_e;

  localparam logic [31:0] PC_RST     = 32'hFFFF_FFFF;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP        = 32'h0000_0000;

endpackage

// File: rtl/if_stage_instr_mem.sv
// Instruction memory: synchronous write port for the debug loader,
// asynchronous read port for fetch.
module instr_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // NOTE: the array has no reset; a loaded program must survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: debug-controlled LOAD/RUN/STEP/HALT FSM, fetch mux,
// PC+1 / PC write-enable generation and the IF/ID pipeline register.
module if_stage #(
  parameter int          MEM_DEPTH  = 256,
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] HALT_INSTR = mips_pkg::HALT_INSTR,
  parameter logic [31:0] PC_RST     = mips_pkg::PC_RST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_PC,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [31:0]       i_load_data,
  input  logic              i_start,
  input  logic              i_step_mode,
  input  logic              i_step,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [31:0]       o_PC_next,
  output logic              o_PC_write,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_IF_ID_PC,
  output logic              o_valid,
  output logic              o_halted,
  output logic [1:0]        o_state
);

  import mips_pkg::*;

  state_e      state_q, state_d;
  logic [31:0] instr_q, if_id_pc_q;
  logic        valid_q;

  logic [31:0] mem_rdata, fetch_word;
  logic        pc_is_rst, pc_out_of_range, halt_det, adv;

  instr_mem #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_instr_mem (
    .clk     (clk),
    .we_i    ((state_q == LOAD) && i_load_en),
    .waddr_i (i_load_addr),
    .wdata_i (i_load_data),
    .raddr_i (i_PC[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  // Sentinel and out-of-range PCs fetch a NOP instead of aliasing into memory.
  assign pc_is_rst       = (i_PC == PC_RST);
  assign pc_out_of_range = |i_PC[31:ADDR_W];
  assign fetch_word      = (pc_is_rst || pc_out_of_range) ? NOP : mem_rdata;
  assign halt_det        = (fetch_word == HALT_INSTR) && !pc_is_rst;

  assign adv        = ((state_q == RUN) || ((state_q == STEP) && i_step)) && !i_stall;
  assign o_PC_write = adv && !halt_det;
  assign o_PC_next  = i_PC + 32'd1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:      if (i_start) state_d = i_step_mode ? STEP : RUN;
      RUN, STEP: if (adv && halt_det) state_d = HALT;
      HALT:      state_d = HALT;
      default:   state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= LOAD;
      instr_q    <= NOP;
      if_id_pc_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (i_flush) begin
        instr_q <= NOP;
        valid_q <= 1'b0;
      end else if (adv) begin
        instr_q    <= fetch_word;
        if_id_pc_q <= o_PC_next;
        valid_q    <= !pc_is_rst;
      end
    end
  end

  assign o_instr    = instr_q;
  assign o_IF_ID_PC = if_id_pc_q;
  assign o_valid    = valid_q;
  assign o_halted   = (state_q == HALT);
  assign o_state    = state_q;

endmodule
